// File: rtl/leaf_adapter_pkg.sv
// Shared types and width helpers for the leaf port adapter and its per-port packer/FIFO.
package leaf_adapter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } unpack_state_t;

    function automatic int user_bits(input int payload_bits, input int pack_ratio);
        return payload_bits * pack_ratio;
    endfunction

    // Index width for n positions; never below one bit so R=1 and tiny FIFOs stay legal.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/leaf_pack_fifo.sv
// Packs PACK_RATIO payload words (first word in LSBs) into one kernel word and queues it
// in a FIFO_DEPTH-entry FIFO that feeds the kernel's ap_vld/ap_ack input stream.
module leaf_pack_fifo
    import leaf_adapter_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int PACK_RATIO   = 2,
    parameter int FIFO_DEPTH   = 4,
    localparam int USER_BITS   = user_bits(PAYLOAD_BITS, PACK_RATIO)
) (
    input  logic                    clk_user,
    input  logic                    reset_n,
    input  logic                    i_live,
    input  logic [PAYLOAD_BITS-1:0] i_payload,
    input  logic                    i_vld,
    output logic                    o_ack,
    output logic [USER_BITS-1:0]    o_word,
    output logic                    o_word_vld,
    input  logic                    i_word_ack
);
    localparam int SW = idx_bits(PACK_RATIO);
    localparam int PW = idx_bits(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [SW-1:0]        r_slot;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [USER_BITS-1:0] r_mem [FIFO_DEPTH];

    logic                 w_accept;
    logic                 w_last;
    logic                 w_push;
    logic                 w_pop;
    logic [USER_BITS-1:0] w_full_word;

    assign o_ack      = i_live && (r_count < CW'(FIFO_DEPTH));
    assign o_word_vld = (r_count != '0);
    assign o_word     = o_word_vld ? r_mem[r_rd_ptr] : '0;

    assign w_accept = i_vld && o_ack;
    assign w_last   = (r_slot == SW'(PACK_RATIO - 1));
    assign w_push   = w_accept && w_last;
    assign w_pop    = o_word_vld && i_word_ack;

    generate
        if (PACK_RATIO > 1) begin : g_pack
            // Only the first R-1 words need staging; the last one goes straight into the push.
            logic [(PACK_RATIO-1)*PAYLOAD_BITS-1:0] r_stage;

            always_ff @(posedge clk_user or negedge reset_n) begin
                if (!reset_n) begin
                    r_stage <= '0;
                end else if (w_accept) begin
                    for (int s = 0; s < PACK_RATIO - 1; s++) begin
                        if (r_slot == SW'(s)) begin
                            r_stage[s*PAYLOAD_BITS +: PAYLOAD_BITS] <= i_payload;
                        end
                    end
                end
            end

            assign w_full_word = {i_payload, r_stage};
        end else begin : g_direct
            assign w_full_word = i_payload;
        end
    endgenerate

    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            r_slot   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_slot <= w_last ? '0 : r_slot + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is not reset; stale entries are hidden because the count gates the output.
    always_ff @(posedge clk_user) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_full_word;
        end
    end

endmodule

// File: rtl/leaf_port_adapter.sv
// Adapts N leaf_interface payload streams to kernel input words (pack + FIFO) and M kernel
// output words back to payload streams (unpack, LSB slice first), all on the user clock.
module leaf_port_adapter
    import leaf_adapter_pkg::*;
#(
    parameter int NUM_IN_PORTS  = 1,
    parameter int NUM_OUT_PORTS = 1,
    parameter int PAYLOAD_BITS  = 32,
    parameter int PACK_RATIO    = 2,
    parameter int FIFO_DEPTH    = 4,
    localparam int USER_BITS    = user_bits(PAYLOAD_BITS, PACK_RATIO)
) (
    input  logic                                clk_user,
    input  logic                                reset_n,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]             vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]             ack_user2interface,
    output logic [NUM_IN_PORTS*USER_BITS-1:0]   Input_V_V,
    output logic [NUM_IN_PORTS-1:0]             Input_V_V_ap_vld,
    input  logic [NUM_IN_PORTS-1:0]             Input_V_V_ap_ack,
    input  logic [NUM_OUT_PORTS*USER_BITS-1:0]  Output_V_V,
    input  logic [NUM_OUT_PORTS-1:0]            Output_V_V_ap_vld,
    output logic [NUM_OUT_PORTS-1:0]            Output_V_V_ap_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]            vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]            ack_interface2user
);
    localparam int IW = idx_bits(PACK_RATIO);

    // Keeps every ack low until the first clock after reset release.
    logic r_live;

    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    genvar gi;

    for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
        leaf_pack_fifo #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .PACK_RATIO   (PACK_RATIO),
            .FIFO_DEPTH   (FIFO_DEPTH)
        ) u_pack_fifo (
            .clk_user   (clk_user),
            .reset_n    (reset_n),
            .i_live     (r_live),
            .i_payload  (dout_leaf_interface2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .i_vld      (vld_interface2user[gi]),
            .o_ack      (ack_user2interface[gi]),
            .o_word     (Input_V_V[gi*USER_BITS +: USER_BITS]),
            .o_word_vld (Input_V_V_ap_vld[gi]),
            .i_word_ack (Input_V_V_ap_ack[gi])
        );
    end

    for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
        unpack_state_t             r_state;
        unpack_state_t             w_state_next;
        logic [IW-1:0]             r_idx;
        logic [IW-1:0]             w_idx_next;
        logic [USER_BITS-1:0]      r_hold;
        logic [USER_BITS-1:0]      w_hold_next;
        logic                      w_vld;
        logic                      w_kack;
        logic                      w_last;
        logic [PAYLOAD_BITS-1:0]   w_din;

        always_ff @(posedge clk_user or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_hold  <= '0;
            end else begin
                r_state <= w_state_next;
                r_idx   <= w_idx_next;
                r_hold  <= w_hold_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_idx_next   = r_idx;
            w_hold_next  = r_hold;
            w_vld        = 1'b0;
            w_kack       = 1'b0;
            w_din        = '0;
            w_last       = (r_idx == IW'(PACK_RATIO - 1));
            case (r_state)
                ST_IDLE: begin
                    w_kack = r_live;
                    if (r_live && Output_V_V_ap_vld[gi]) begin
                        w_hold_next  = Output_V_V[gi*USER_BITS +: USER_BITS];
                        w_idx_next   = '0;
                        w_state_next = ST_SEND;
                    end
                end
                ST_SEND: begin
                    w_vld = 1'b1;
                    for (int s = 0; s < PACK_RATIO; s++) begin
                        if (r_idx == IW'(s)) begin
                            w_din = r_hold[s*PAYLOAD_BITS +: PAYLOAD_BITS];
                        end
                    end
                    if (ack_interface2user[gi]) begin
                        if (w_last) begin
                            // Taking the next kernel word on the last slice keeps one slice per cycle.
                            w_kack     = 1'b1;
                            w_idx_next = '0;
                            if (Output_V_V_ap_vld[gi]) begin
                                w_hold_next = Output_V_V[gi*USER_BITS +: USER_BITS];
                            end else begin
                                w_state_next = ST_IDLE;
                            end
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        assign vld_user2interface[gi]                                      = w_vld;
        assign Output_V_V_ap_ack[gi]                                       = w_kack;
        assign din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = w_din;
    end

endmodule

// File: tb/tb_leaf_port_adapter.sv
// Checks leaf_port_adapter (3 in / 3 out, P=32, R=2, depth 4) against a queue-based model.
module tb_leaf_port_adapter;
    localparam int N  = 3;
    localparam int M  = 3;
    localparam int P  = 32;
    localparam int R  = 2;
    localparam int D  = 4;
    localparam int UB = P * R;

    logic           clk_user = 1'b0;
    logic           reset_n  = 1'b0;
    logic [N*P-1:0] dout_leaf_interface2user;
    logic [N-1:0]   vld_interface2user;
    logic [N-1:0]   ack_user2interface;
    logic [N*UB-1:0] Input_V_V;
    logic [N-1:0]   Input_V_V_ap_vld;
    logic [N-1:0]   Input_V_V_ap_ack;
    logic [M*UB-1:0] Output_V_V;
    logic [M-1:0]   Output_V_V_ap_vld;
    logic [M-1:0]   Output_V_V_ap_ack;
    logic [M*P-1:0] din_leaf_user2interface;
    logic [M-1:0]   vld_user2interface;
    logic [M-1:0]   ack_interface2user;

    always #5 clk_user = ~clk_user;

    leaf_port_adapter #(
        .NUM_IN_PORTS  (N),
        .NUM_OUT_PORTS (M),
        .PAYLOAD_BITS  (P),
        .PACK_RATIO    (R),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk_user                 (clk_user),
        .reset_n                  (reset_n),
        .dout_leaf_interface2user (dout_leaf_interface2user),
        .vld_interface2user       (vld_interface2user),
        .ack_user2interface       (ack_user2interface),
        .Input_V_V                (Input_V_V),
        .Input_V_V_ap_vld         (Input_V_V_ap_vld),
        .Input_V_V_ap_ack         (Input_V_V_ap_ack),
        .Output_V_V               (Output_V_V),
        .Output_V_V_ap_vld        (Output_V_V_ap_vld),
        .Output_V_V_ap_ack        (Output_V_V_ap_ack),
        .din_leaf_user2interface  (din_leaf_user2interface),
        .vld_user2interface       (vld_user2interface),
        .ack_interface2user       (ack_interface2user)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: whole kernel words per input port, pending payload slices per output port.
    logic [UB-1:0] in_q   [N][$];
    logic [P-1:0]  part_q [N][$];
    logic [P-1:0]  out_q  [M][$];
    bit            live_m = 1'b0;

    // Port-0 samples from the most recent cycle, for directed checks.
    logic [P-1:0]  s_din0;
    logic          s_vld0;
    logic          s_kack0;
    int            acc0;

    task automatic idle_inputs();
        dout_leaf_interface2user = '0;
        vld_interface2user       = '0;
        Input_V_V_ap_ack         = '0;
        Output_V_V               = '0;
        Output_V_V_ap_vld        = '0;
        ack_interface2user       = '0;
    endtask

    task automatic rand_inputs(input int pv, input int pa, input int pk, input int pi);
        for (int i = 0; i < N; i++) begin
            vld_interface2user[i]            = ($urandom_range(99) < pv);
            dout_leaf_interface2user[i*P +: P] = $urandom();
            Input_V_V_ap_ack[i]              = ($urandom_range(99) < pa);
        end
        for (int j = 0; j < M; j++) begin
            Output_V_V_ap_vld[j]     = ($urandom_range(99) < pk);
            Output_V_V[j*UB +: UB]   = {$urandom(), $urandom()};
            ack_interface2user[j]    = ($urandom_range(99) < pi);
        end
    endtask

    // Called at a falling edge with inputs already driven; checks, advances the model, and
    // returns at the next falling edge.
    task automatic cycle();
        bit            exp_ack, exp_v, exp_kack, kx, ifx, pop;
        logic [UB-1:0] w;
        #1;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                in_q[i].delete();
                part_q[i].delete();
            end
            for (int j = 0; j < M; j++) out_q[j].delete();
            live_m = 1'b0;
            check_val("rst_input_word", Input_V_V, '0);
            check_val("rst_din", din_leaf_user2interface, '0);
        end
        for (int i = 0; i < N; i++) begin
            exp_ack = live_m && (in_q[i].size() < D);
            exp_v   = (in_q[i].size() != 0);
            check_val($sformatf("ack_user2interface[%0d]", i), ack_user2interface[i], exp_ack);
            check_val($sformatf("Input_V_V_ap_vld[%0d]", i), Input_V_V_ap_vld[i], exp_v);
            if (exp_v) check_val($sformatf("Input_V_V[%0d]", i), Input_V_V[i*UB +: UB], in_q[i][0]);
            if (reset_n) begin
                pop = exp_v && Input_V_V_ap_ack[i];
                if (vld_interface2user[i] && exp_ack) begin
                    part_q[i].push_back(dout_leaf_interface2user[i*P +: P]);
                    if (part_q[i].size() == R) begin
                        w = '0;
                        for (int k = 0; k < R; k++) w[k*P +: P] = part_q[i][k];
                        in_q[i].push_back(w);
                        part_q[i].delete();
                    end
                end
                if (pop) begin
                    $display("[TB] in%0d kernel word %h", i, in_q[i][0]);
                    void'(in_q[i].pop_front());
                end
            end
        end
        for (int j = 0; j < M; j++) begin
            exp_v    = (out_q[j].size() != 0);
            exp_kack = live_m && ((out_q[j].size() == 0) ||
                                  (out_q[j].size() == 1 && ack_interface2user[j]));
            check_val($sformatf("vld_user2interface[%0d]", j), vld_user2interface[j], exp_v);
            check_val($sformatf("Output_V_V_ap_ack[%0d]", j), Output_V_V_ap_ack[j], exp_kack);
            if (exp_v) check_val($sformatf("din[%0d]", j), din_leaf_user2interface[j*P +: P], out_q[j][0]);
            if (reset_n) begin
                ifx = exp_v && ack_interface2user[j];
                kx  = Output_V_V_ap_vld[j] && exp_kack;
                if (ifx) void'(out_q[j].pop_front());
                if (kx) begin
                    $display("[TB] out%0d kernel word %h", j, Output_V_V[j*UB +: UB]);
                    for (int k = 0; k < R; k++) out_q[j].push_back(Output_V_V[j*UB + k*P +: P]);
                end
            end
        end
        s_din0  = din_leaf_user2interface[P-1:0];
        s_vld0  = vld_user2interface[0];
        s_kack0 = Output_V_V_ap_ack[0];
        if (reset_n && vld_interface2user[0] && ack_user2interface[0]) acc0++;
        if (reset_n) live_m = 1'b1;
        @(negedge clk_user);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk_user);

        // Reset held with traffic offered on every port.
        vld_interface2user = '1;
        Output_V_V_ap_vld  = '1;
        ack_interface2user = '1;
        repeat (5) cycle();
        idle_inputs();
        reset_n = 1'b1;
        cycle();
        check_val("first_ack", ack_user2interface[0], 1'b1);

        // Two payloads pack into one kernel word, LSB first.
        vld_interface2user[0]    = 1'b1;
        dout_leaf_interface2user[P-1:0] = 32'h11111111;
        cycle();
        dout_leaf_interface2user[P-1:0] = 32'h22222222;
        cycle();
        vld_interface2user[0] = 1'b0;
        check_val("pack_vld", Input_V_V_ap_vld[0], 1'b1);
        check_val("pack_word", Input_V_V[UB-1:0], 64'h22222222_11111111);
        Input_V_V_ap_ack[0] = 1'b1;
        cycle();
        Input_V_V_ap_ack[0] = 1'b0;

        // Backpressure: 10 payloads offered, kernel stalled.
        acc0 = 0;
        vld_interface2user[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            dout_leaf_interface2user[P-1:0] = 32'hB000_0000 + k;
            cycle();
        end
        vld_interface2user[0] = 1'b0;
        check_val("bp_accepted", acc0, 8);
        check_val("bp_ack_full", ack_user2interface[0], 1'b0);
        Input_V_V_ap_ack[0] = 1'b1;
        cycle();
        Input_V_V_ap_ack[0] = 1'b0;
        check_val("bp_ack_back", ack_user2interface[0], 1'b1);
        Input_V_V_ap_ack[0] = 1'b1;
        repeat (5) cycle();
        Input_V_V_ap_ack[0] = 1'b0;
        check_val("bp_drained", Input_V_V_ap_vld[0], 1'b0);

        // Back-to-back unpack.
        ack_interface2user[0] = 1'b1;
        Output_V_V_ap_vld[0]  = 1'b1;
        Output_V_V[UB-1:0]    = 64'hAAAAAAAA_BBBBBBBB;
        cycle();
        check_val("unp_take1", s_kack0, 1'b1);
        Output_V_V[UB-1:0]    = 64'hCCCCCCCC_DDDDDDDD;
        cycle();
        check_val("unp_s0", s_din0, 32'hBBBBBBBB);
        check_val("unp_s0_kack", s_kack0, 1'b0);
        cycle();
        check_val("unp_s1", s_din0, 32'hAAAAAAAA);
        check_val("unp_s1_kack", s_kack0, 1'b1);
        Output_V_V_ap_vld[0]  = 1'b0;
        cycle();
        check_val("unp_s2", s_din0, 32'hDDDDDDDD);
        cycle();
        check_val("unp_s3", s_din0, 32'hCCCCCCCC);
        check_val("unp_s3_kack", s_kack0, 1'b1);
        cycle();
        check_val("unp_idle", s_vld0, 1'b0);

        // Multi-port random traffic in three pressure regimes.
        for (int c = 0; c < 600; c++) begin
            if (c < 200)      rand_inputs(70, 50, 60, 70);
            else if (c < 400) rand_inputs(90, 15, 80, 25);
            else              rand_inputs(40, 90, 30, 95);
            cycle();
        end
        idle_inputs();
        Input_V_V_ap_ack   = '1;
        ack_interface2user = '1;
        repeat (8) cycle();

        // Reset after the first of two slices.
        Output_V_V_ap_vld[0] = 1'b1;
        Output_V_V[UB-1:0]   = 64'h55555555_66666666;
        cycle();
        Output_V_V_ap_vld[0] = 1'b0;
        cycle();
        check_val("mid_s0", s_din0, 32'h66666666);
        reset_n = 1'b0;
        cycle();
        check_val("mid_rst_vld", s_vld0, 1'b0);
        cycle();
        reset_n = 1'b1;
        cycle();
        check_val("mid_post_vld", s_vld0, 1'b0);
        cycle();
        Output_V_V_ap_vld[0] = 1'b1;
        Output_V_V[UB-1:0]   = 64'h77777777_88888888;
        cycle();
        Output_V_V_ap_vld[0] = 1'b0;
        cycle();
        check_val("mid_new_s0", s_din0, 32'h88888888);
        cycle();
        check_val("mid_new_s1", s_din0, 32'h77777777);
        cycle();
        check_val("mid_done", s_vld0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/leaf_port_adapter.md
# leaf_port_adapter

Parametrised adapter between the leaf_interface per-port payload streams and a user HLS kernel's ap_vld/ap_ack streams, inserted in a leaf between the interface and the kernel. It generalises the fixed 1-in/1-out, 32-bit direct hookup to N input and M output ports, with width packing/unpacking (kernel word = PACK_RATIO payload words) and a per-input-port FIFO. The whole block runs on the user clock.

## Interface
- NUM_IN_PORTS, 1, interface→kernel channels
- NUM_OUT_PORTS, 1, kernel→interface channels
- PAYLOAD_BITS, 32, leaf_interface payload width P
- PACK_RATIO, 2, payload words per kernel word R (≥1); USER_BITS = P·R
- FIFO_DEPTH, 4, kernel words per input FIFO (power of 2, ≥2)

- clk_user  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- dout_leaf_interface2user  in  NUM_IN_PORTS·P  payload from interface, port i at [i·P +: P]
- vld_interface2user  in  NUM_IN_PORTS  payload valid
- ack_user2interface  out  NUM_IN_PORTS  payload accepted
- Input_V_V  out  NUM_IN_PORTS·USER_BITS  kernel input words
- Input_V_V_ap_vld  out  NUM_IN_PORTS  kernel input valid
- Input_V_V_ap_ack  in  NUM_IN_PORTS  kernel consumed word
- Output_V_V  in  NUM_OUT_PORTS·USER_BITS  kernel output words
- Output_V_V_ap_vld  in  NUM_OUT_PORTS  kernel output valid
- Output_V_V_ap_ack  out  NUM_OUT_PORTS  word taken by adapter
- din_leaf_user2interface  out  NUM_OUT_PORTS·P  payload to interface
- vld_user2interface  out  NUM_OUT_PORTS  payload valid
- ack_interface2user  in  NUM_OUT_PORTS  interface accepted payload

## Operation
- Handshake everywhere: transfer occurs on a cycle with vld and ack both high; no other cycle moves data.
- Live flop: cleared by reset, set first clock after reset_n rises; all acks gated by it.
- Input path (per port i): packer slot index k (0..R-1) and staging register. Accepted word k lands at staging[k·P +: P] (first word in LSBs). On acceptance of word R-1, the full word (staging plus current payload) is pushed to the FIFO in the same cycle; k wraps to 0.
- ack_user2interface[i] = live && fifo_count < FIFO_DEPTH, from registered state only.
- Input_V_V_ap_vld[i] = FIFO non-empty; Input_V_V[i] = head word; pop on ap_vld && ap_ack.
- Simultaneous push and pop: count unchanged, pointers both advance. Full: no push possible (ack low); a pop re-raises ack next cycle.
- Output path (per port j): states IDLE, SEND. IDLE: Output_V_V_ap_ack = live; on transfer, load hold register, idx=0, go SEND. SEND: vld_user2interface=1, din = hold[idx·P +: P]; each transfer increments idx. On transfer at idx=R-1: Output_V_V_ap_ack high this cycle (combinational from ack_interface2user); if kernel vld also high, reload and stay in SEND with idx=0, else IDLE.
- R=1: packer degenerates to direct FIFO push; unpacker to one-slice SEND.
- Reset mid-operation: partial packed words, FIFO contents and in-flight hold words are discarded; no output glitch beyond the asynchronous clear.

## Timing
- Reset values: ack_user2interface=0, Input_V_V_ap_vld=0, Output_V_V_ap_ack=0, vld_user2interface=0, data outputs 0.
- Input latency: R-th payload accepted at cycle t → Input_V_V_ap_vld high at t+1 (FIFO previously empty).
- Input throughput: one payload per cycle while FIFO not full.
- Output latency: kernel word taken at t → first slice valid at t+1; back-to-back words sustain one slice per cycle (R cycles per word).
- Only combinational path: ack_interface2user → Output_V_V_ap_ack.

## Structure
- Package leaf_adapter_pkg: USER_BITS derivation, clog2-based pointer/count width function, state encoding (IDLE=0, SEND=1).
- Sub-module leaf_pack_fifo (packer + FIFO), generate-instantiated per input port; unpacker coded inline in a generate loop.

## Test plan
- Reset: hold reset_n low 5 cycles with vld inputs high → all acks/vld 0; first ack rises cycle after release.
- Pack: P=32, R=2, send 0x11111111, 0x22222222 → Input_V_V=0x22222222_11111111, ap_vld at next cycle.
- Backpressure: FIFO_DEPTH=4, kernel ack low, stream 10 payloads → ack_user2interface drops after 8 accepted; one pop → ack high next cycle, no data lost or duplicated.
- Unpack back-to-back: two kernel words 0xA..B, 0xC..D with interface ack always high → slices B,A,D,C on 4 consecutive cycles, ap_ack high at word boundaries.
- Multi-port: NUM_IN_PORTS=NUM_OUT_PORTS=3, random vld/ack per port → per-port ordered scoreboard match, ports independent.
- Mid-stream reset after one of two slices → no further vld; post-reset word unpacked from idx 0.
